scanline_shifter: RTL and testbench

SCANLINE_SHIFTER -- requirements
Module: scanline_shifter

---
 rtl/scanline_shifter.sv | 151 +++++++++++++++
 tb/tb_scanline_shifter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/scanline_shifter.sv
// scanline_shifter
//   Serializes one scanline of 1-bpp pixels from a byte-wide scanline RAM.
//   A line_start request loads byte 0 and then emits pixels MSB first, one
//   per pix_en strobe, fetching the next byte without a bubble.
//   It pulses line_done once after the last pixel of the line is consumed.
//
// Ports
//   clk        : clock, all logic on posedge
//   rst_n      : asynchronous active-low reset
//   line_start : one-cycle request to start a line (honoured only in IDLE)
//   pix_en     : pixel strobe, consumes the presented pixel
//   hflip      : (SCANLINE_HFLIP_EN only) mirror the line, sampled at start
//   ram_addr   : scanline RAM read address
//   ram_data   : RAM byte at ram_addr, combinational read
//   pix_out    : current pixel
//   pix_valid  : pix_out is valid
//   pix_x      : column of the presented pixel
//   busy       : high while loading or shifting
//   line_done  : one-cycle pulse after the last pixel
//
// Optional feature: define SCANLINE_HFLIP_EN to add the hflip input.

module scanline_shifter #(
  parameter int unsigned NUM_BYTES = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_start,
  input  logic       pix_en,
`ifdef SCANLINE_HFLIP_EN
  input  logic       hflip,
`endif
  output logic [4:0] ram_addr,
  input  logic [7:0] ram_data,
  output logic       pix_out,
  output logic       pix_valid,
  output logic [7:0] pix_x,
  output logic       busy,
  output logic       line_done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  localparam logic [4:0] END_IDX  = 5'(NUM_BYTES);
  localparam logic [4:0] LAST_IDX = 5'(NUM_BYTES - 1);

  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q,   bit_d;
  logic [4:0]  idx_q,   idx_d;   // number of bytes already fetched this line
  logic [7:0]  x_q,     x_d;
  logic        flip;

`ifdef SCANLINE_HFLIP_EN
  logic flip_q, flip_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flip_q <= 1'b0;
    else        flip_q <= flip_d;
  end

  always_comb begin
    flip_d = flip_q;
    if (state_q == IDLE && line_start) flip_d = hflip;
  end

  assign flip = flip_q;
`else
  assign flip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    x_d     = x_q;
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        bit_d = '0;
        x_d   = '0;
        if (line_start) state_d = LOAD;
      end
      LOAD: begin
        shift_d = ram_data;
        idx_d   = 5'd1;
        bit_d   = '0;
        x_d     = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (pix_en) begin
          if (bit_q != 3'd7) begin
            shift_d = flip ? (shift_q >> 1) : (shift_q << 1);
            bit_d   = bit_q + 3'd1;
            x_d     = x_q + 8'd1;
          end else if (idx_q < END_IDX) begin
            shift_d = ram_data;
            idx_d   = idx_q + 5'd1;
            bit_d   = '0;
            x_d     = x_q + 8'd1;
          end else begin
            shift_d = '0;
            idx_d   = '0;
            bit_d   = '0;
            x_d     = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address is derived from the fetch count so both scan directions share one
  // counter; the mirrored address clamps at 0 once every byte has been fetched.
  always_comb begin
    ram_addr = '0;
    if (state_q == LOAD || state_q == SHIFT) begin
      if (flip) ram_addr = (idx_q >= END_IDX) ? '0 : (LAST_IDX - idx_q);
      else      ram_addr = idx_q;
    end
  end

  assign pix_valid = (state_q == SHIFT);
  assign pix_out   = pix_valid & (flip ? shift_q[0] : shift_q[7]);
  assign pix_x     = pix_valid ? x_q : '0;
  assign busy      = (state_q == LOAD) || (state_q == SHIFT);
  assign line_done = (state_q == DONE);

endmodule

// File: tb/tb_scanline_shifter.sv
module tb_scanline_shifter;

  localparam int NB    = 20;
  localparam int TOTAL = 8 * NB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       line_start;
  logic       pix_en;
  logic [4:0] ram_addr;
  logic [7:0] ram_data;
  logic       pix_out;
  logic       pix_valid;
  logic [7:0] pix_x;
  logic       busy;
  logic       line_done;
`ifdef SCANLINE_HFLIP_EN
  logic       hflip;
`endif

  logic [7:0] mem [NB];

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign ram_data = (int'(ram_addr) < NB) ? mem[ram_addr] : 8'h00;

  scanline_shifter #(.NUM_BYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_start(line_start),
    .pix_en    (pix_en),
`ifdef SCANLINE_HFLIP_EN
    .hflip     (hflip),
`endif
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .pix_out   (pix_out),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .busy      (busy),
    .line_done (line_done)
  );

  task automatic check(input string tag, input int obs, input int exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: pixel i of the line, straight from the RAM image.
  function automatic int ref_pixel(input int i, input bit f);
    logic [7:0] b;
    b = f ? mem[NB - 1 - i / 8] : mem[i / 8];
    return f ? int'(b[i % 8]) : int'(b[7 - i % 8]);
  endfunction

  // Reference: RAM address presented while pixel k is on the output.
  function automatic int ref_addr(input int k, input bit f);
    int a;
    if (f) begin
      a = NB - 2 - k / 8;
      return (a < 0) ? 0 : a;
    end
    return k / 8 + 1;
  endfunction

  // en_mode: 0 continuous, 1 pattern 1,0,0,1, 2 random.
  // Called at a negedge; returns at a negedge.
  task automatic run_line(input int en_mode, input bit f, input int restart_at,
                          input int abort_at);
    int consumed = 0;
    int dones    = 0;
    bit en;
    line_start = 1'b1;
    pix_en     = 1'($urandom_range(0, 1));  // dropped when start is taken
`ifdef SCANLINE_HFLIP_EN
    hflip = f;
`endif
    @(negedge clk);
    line_start = 1'b0;
    check("load_busy",  int'(busy), 1);
    check("load_valid", int'(pix_valid), 0);
    check("load_addr",  int'(ram_addr), f ? NB - 1 : 0);
    pix_en = 1'($urandom_range(0, 1));      // ignored during LOAD
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (consumed == TOTAL) begin
        check("done_pulse", int'(line_done), 1);
        check("done_valid", int'(pix_valid), 0);
        dones++;
        pix_en = 1'b0;
        @(negedge clk);
        check("after_done", int'(line_done), 0);
        check("after_busy", int'(busy), 0);
        check("done_count", dones, 1);
        return;
      end
      check("valid", int'(pix_valid), 1);
      check("pix",   int'(pix_out), ref_pixel(consumed, f));
      check("pix_x", int'(pix_x), consumed);
      check("addr",  int'(ram_addr), ref_addr(consumed, f));
      check("early_done", int'(line_done), 0);
      if (abort_at >= 0 && consumed == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_valid", int'(pix_valid), 0);
        check("abort_busy",  int'(busy), 0);
        check("abort_done",  int'(line_done), 0);
        check("abort_addr",  int'(ram_addr), 0);
        check("abort_x",     int'(pix_x), 0);
        #2;
        rst_n  = 1'b1;
        pix_en = 1'b0;
        return;
      end
      line_start = (consumed == restart_at);
      case (en_mode)
        0:       en = 1'b1;
        1:       en = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: en = ($urandom_range(0, 3) != 0);
      endcase
      pix_en = en;
      if (en) consumed++;
    end
    check("timeout", 0, 1);
    line_start = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    rst_n      = 1'b0;
    line_start = 1'b0;
    pix_en     = 1'b0;
`ifdef SCANLINE_HFLIP_EN
    hflip = 1'b0;
`endif
    fill_random();
    repeat (3) @(negedge clk);
    check("rst_pix",   int'(pix_out), 0);
    check("rst_valid", int'(pix_valid), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_done",  int'(line_done), 0);
    check("rst_addr",  int'(ram_addr), 0);
    check("rst_x",     int'(pix_x), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix_en = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_busy",  int'(busy), 0);
      check("idle_valid", int'(pix_valid), 0);
      check("idle_addr",  int'(ram_addr), 0);
    end

    // single set pixels at both ends of the line
    for (int i = 0; i < NB; i++) mem[i] = 8'h00;
    mem[0] = 8'h80;
    mem[NB - 1] = 8'h01;
    run_line(0, 1'b0, -1, -1);

    // byte boundary with no gap
    fill_random();
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
    run_line(0, 1'b0, -1, -1);

    // stalled strobe pattern with an ignored restart mid-line
    fill_random();
    run_line(1, 1'b0, 50, -1);

    // reset mid-line, then a start right on the first edge after release
    fill_random();
    run_line(2, 1'b0, -1, 80);
    fill_random();
    run_line(2, 1'b0, 10, -1);

`ifdef SCANLINE_HFLIP_EN
    for (int i = 0; i < NB; i++) mem[i] = 8'h00;
    mem[NB - 1] = 8'h01;
    run_line(0, 1'b1, -1, -1);
    fill_random();
    run_line(2, 1'b1, -1, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
